// File: rtl/ext_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ext_sram_bridge
// Description : Bridges a 32-bit external-memory request onto a 16-bit
//               asynchronous SRAM. Each request becomes one or two halfword
//               beats (SETUP then ACCESS), with programmable wait states and
//               SRAM-driven stretching. Write beats with no enabled bytes are
//               skipped.
//               Optional feature macro: EXT_SRAM_TIMEOUT_EN (aborts a beat
//               stretched for TIMEOUT_CYCLES cycles and flags bus_err).
// Revision    : 1.0 - initial release
// ============================================================================
module ext_sram_bridge #(
    parameter int WAIT_STATES    = 1,
    parameter int SRAM_AW        = 20,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_enable,
    input  logic               req_read,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_be,
    output logic [31:0]        req_rdata,
    output logic               req_ready,
    output logic               req_busy,
    output logic               bus_err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_ce,
    output logic               sram_oe,
    output logic               sram_we,
    output logic [1:0]         sram_bls,
    input  logic               sram_wait
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SETUP_LO = 3'd1;
    localparam logic [2:0] c_ST_ACC_LO   = 3'd2;
    localparam logic [2:0] c_ST_SETUP_HI = 3'd3;
    localparam logic [2:0] c_ST_ACC_HI   = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

    logic [2:0]         r_state;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [SRAM_AW-2:0] r_addr;
    logic [3:0]         r_wait_cnt;

    logic w_accept;
    logic w_first_hi;
    logic w_skip_all;
    logic w_in_hi;
    logic w_beat_done;
    logic w_need_hi;
    logic w_unused_addr;

    // A write with both read and write asserted is treated as a write.
    assign w_accept    = req_enable & (req_read | req_write);
    assign w_first_hi  = req_write & (req_be[1:0] == 2'b00);
    assign w_skip_all  = req_write & (req_be == 4'h0);
    assign w_in_hi     = (r_state == c_ST_ACC_HI);
    assign w_beat_done = (r_wait_cnt == 4'd0) & ~sram_wait;
    assign w_need_hi   = ~r_write | (r_be[3:2] != 2'b00);

    // Byte-lane bits and bits above the SRAM window alias away.
    assign w_unused_addr = ^{req_addr[31:SRAM_AW+1], req_addr[1:0]};

`ifdef EXT_SRAM_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_to_cnt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Transaction sequencer: all SRAM strobes and handshake outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_write    <= 1'b0;
            r_wdata    <= 32'h0;
            r_be       <= 4'h0;
            r_addr     <= '0;
            r_wait_cnt <= 4'd0;
            req_rdata  <= 32'h0;
            req_ready  <= 1'b0;
            req_busy   <= 1'b0;
            bus_err    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 16'h0;
            sram_ce    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_bls   <= 2'b00;
`ifdef EXT_SRAM_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            req_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_write  <= req_write;
                        r_wdata  <= req_wdata;
                        r_be     <= req_be;
                        r_addr   <= req_addr[SRAM_AW:2];
                        req_busy <= 1'b1;
                        if (w_skip_all) begin
                            r_state   <= c_ST_DONE;
                            req_ready <= 1'b1;
                        end else begin
                            r_state    <= w_first_hi ? c_ST_SETUP_HI : c_ST_SETUP_LO;
                            sram_ce    <= 1'b1;
                            sram_addr  <= {req_addr[SRAM_AW:2], w_first_hi};
                            sram_wdata <= w_first_hi ? req_wdata[31:16] : req_wdata[15:0];
                            sram_bls   <= !req_write ? 2'b11 :
                                          (w_first_hi ? req_be[3:2] : req_be[1:0]);
                        end
                    end
                end

                c_ST_SETUP_LO, c_ST_SETUP_HI: begin
                    r_state    <= (r_state == c_ST_SETUP_HI) ? c_ST_ACC_HI : c_ST_ACC_LO;
                    r_wait_cnt <= c_WAIT_INIT;
                    sram_we    <= r_write;
                    sram_oe    <= ~r_write;
`ifdef EXT_SRAM_TIMEOUT_EN
                    r_to_cnt   <= '0;
`endif
                end

                c_ST_ACC_LO, c_ST_ACC_HI: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                    if (w_beat_done) begin
                        sram_oe <= 1'b0;
                        sram_we <= 1'b0;
                        if (!r_write) begin
                            if (w_in_hi) req_rdata[31:16] <= sram_rdata;
                            else         req_rdata[15:0]  <= sram_rdata;
                        end
                        if (!w_in_hi && w_need_hi) begin
                            r_state    <= c_ST_SETUP_HI;
                            sram_addr  <= {r_addr, 1'b1};
                            sram_wdata <= r_wdata[31:16];
                            sram_bls   <= r_write ? r_be[3:2] : 2'b11;
                        end else begin
                            r_state   <= c_ST_DONE;
                            sram_ce   <= 1'b0;
                            req_ready <= 1'b1;
                        end
                    end
`ifdef EXT_SRAM_TIMEOUT_EN
                    else if (sram_wait) begin
                        if (r_to_cnt == c_TO_LAST) begin
                            r_state   <= c_ST_DONE;
                            sram_ce   <= 1'b0;
                            sram_oe   <= 1'b0;
                            sram_we   <= 1'b0;
                            req_ready <= 1'b1;
                            bus_err   <= 1'b1;
                            req_rdata <= 32'hDEADBEEF;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_ONE;
                        end
                    end
`endif
                end

                c_ST_DONE: begin
                    r_state  <= c_ST_IDLE;
                    req_busy <= 1'b0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_sram_bridge
// Description : Directed self-checking bench for ext_sram_bridge (W=1).
//               Latency n means req_ready is seen n cycles after the IDLE
//               cycle in which the request was first presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_sram_bridge;

    localparam int W = 1;
`ifdef EXT_SRAM_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    logic        clk;
    logic        rst;
    logic        req_enable, req_read, req_write;
    logic [31:0] req_addr, req_wdata, req_rdata;
    logic [3:0]  req_be;
    logic        req_ready, req_busy, bus_err;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_ce, sram_oe, sram_we, sram_wait;
    logic [1:0]  sram_bls;

    logic [15:0] mem_lo, mem_hi;

    int n_tests = 0;
    int n_fail  = 0;

    int          ce_cycles, oe_cycles, we_cycles, n_log;
    logic [19:0] log_addr [8];
    logic [15:0] log_data [8];
    logic [1:0]  log_bls  [8];
    logic        prev_we;

    ext_sram_bridge #(
        .WAIT_STATES    (W),
        .SRAM_AW        (20),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_enable (req_enable),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_rdata  (req_rdata),
        .req_ready  (req_ready),
        .req_busy   (req_busy),
        .bus_err    (bus_err),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ce    (sram_ce),
        .sram_oe    (sram_oe),
        .sram_we    (sram_we),
        .sram_bls   (sram_bls),
        .sram_wait  (sram_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-word SRAM model selected by the beat bit.
    assign sram_rdata = sram_addr[0] ? mem_hi : mem_lo;

    // Bus monitor: strobe cycle counts and one log entry per write pulse.
    always @(negedge clk) begin
        if (sram_ce) ce_cycles++;
        if (sram_oe) oe_cycles++;
        if (sram_we) begin
            we_cycles++;
            if (!prev_we && n_log < 8) begin
                log_addr[n_log] = sram_addr;
                log_data[n_log] = sram_wdata;
                log_bls[n_log]  = sram_bls;
                n_log++;
            end
        end
        prev_we = sram_we;
    end

    task automatic clear_mon();
        ce_cycles = 0; oe_cycles = 0; we_cycles = 0; n_log = 0;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        req_enable = 1'b1; req_read = rd; req_write = wr;
        req_addr = addr; req_wdata = wdata; req_be = be;
    endtask

    task automatic drop_req();
        req_enable = 1'b0; req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int lat, output logic [31:0] data, output logic err);
        @(negedge clk);
        clear_mon();
        drive_req(rd, wr, addr, wdata, be);
        lat = -1; data = 32'hx; err = 1'bx;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (req_ready) begin
                lat = n; data = req_rdata; err = bus_err;
                break;
            end
        end
        drop_req();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if ({req_rdata, req_ready, req_busy, bus_err, sram_addr, sram_wdata, sram_ce, sram_oe, sram_we, sram_bls} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got rdata=%h rdy=%b busy=%b err=%b addr=%h ce=%b oe=%b we=%b expected all zero",
                               req_rdata, req_ready, req_busy, bus_err, sram_addr, sram_ce, sram_oe, sram_we); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (req_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", req_busy); end
    endtask

    task automatic test_word_write();
        int lat; logic [31:0] d; logic e;
        run_req(1'b0, 1'b1, 32'h0010_0008, 32'hCAFEBABE, 4'hF, lat, d, e);
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL word_write_latency: got %0d expected 7", lat); end
        n_tests++; if (n_log !== 2 || we_cycles !== 4) begin n_fail++; $display("FAIL word_write_pulses: got %0d pulses/%0d cycles expected 2/4", n_log, we_cycles); end
        n_tests++; if ({log_addr[0], log_data[0], log_bls[0]} !== {20'h80004, 16'hBABE, 2'b11}) begin
            n_fail++; $display("FAIL word_write_lo_beat: got addr=%h data=%h bls=%b expected 80004 babe 11", log_addr[0], log_data[0], log_bls[0]); end
        n_tests++; if ({log_addr[1], log_data[1], log_bls[1]} !== {20'h80005, 16'hCAFE, 2'b11}) begin
            n_fail++; $display("FAIL word_write_hi_beat: got addr=%h data=%h bls=%b expected 80005 cafe 11", log_addr[1], log_data[1], log_bls[1]); end
        n_tests++; if (oe_cycles !== 0 || ce_cycles !== 6) begin n_fail++; $display("FAIL word_write_ce_oe: got ce=%0d oe=%0d expected 6 0", ce_cycles, oe_cycles); end
    endtask

    task automatic test_word_read();
        int lat; logic [31:0] d; logic e;
        mem_lo = 16'h1234; mem_hi = 16'hABCD;
        run_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, lat, d, e);
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL word_read_latency: got %0d expected 7", lat); end
        n_tests++; if (d !== 32'hABCD1234) begin n_fail++; $display("FAIL word_read_data: got %h expected abcd1234", d); end
        n_tests++; if (oe_cycles !== 4 || we_cycles !== 0) begin n_fail++; $display("FAIL word_read_strobes: got oe=%0d we=%0d expected 4 0", oe_cycles, we_cycles); end
        mem_lo = 16'h0; mem_hi = 16'h0;
        repeat (3) @(negedge clk);
        n_tests++; if (req_rdata !== 32'hABCD1234) begin n_fail++; $display("FAIL read_data_hold: got %h expected abcd1234", req_rdata); end
    endtask

    task automatic test_partial_write();
        int lat; logic [31:0] d; logic e;
        run_req(1'b0, 1'b1, 32'h0000_0100, 32'h0055_0000, 4'b0100, lat, d, e);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL byte_write_latency: got %0d expected 4", lat); end
        n_tests++; if (n_log !== 1 || ce_cycles !== 3 || {log_addr[0], log_data[0], log_bls[0]} !== {20'h00081, 16'h0055, 2'b01}) begin
            n_fail++; $display("FAIL byte_write_beat: got n=%0d ce=%0d addr=%h data=%h bls=%b expected 1 3 00081 0055 01",
                               n_log, ce_cycles, log_addr[0], log_data[0], log_bls[0]); end
        run_req(1'b0, 1'b1, 32'h0000_0104, 32'h1111_2222, 4'b0011, lat, d, e);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL lo_only_latency: got %0d expected 4", lat); end
        n_tests++; if (n_log !== 1 || {log_addr[0], log_data[0], log_bls[0]} !== {20'h00082, 16'h2222, 2'b11}) begin
            n_fail++; $display("FAIL lo_only_beat: got n=%0d addr=%h data=%h bls=%b expected 1 00082 2222 11", n_log, log_addr[0], log_data[0], log_bls[0]); end
        run_req(1'b0, 1'b1, 32'h0000_0108, 32'hFFFF_FFFF, 4'h0, lat, d, e);
        n_tests++; if (lat !== 1 || ce_cycles !== 0) begin n_fail++; $display("FAIL be_zero: got lat=%0d ce=%0d expected 1 0", lat, ce_cycles); end
        run_req(1'b1, 1'b1, 32'h0000_0010, 32'h0102_0304, 4'hF, lat, d, e);
        n_tests++; if (lat !== 7 || we_cycles !== 4 || oe_cycles !== 0) begin
            n_fail++; $display("FAIL rd_wr_both: got lat=%0d we=%0d oe=%0d expected 7 4 0", lat, we_cycles, oe_cycles); end
        n_tests++; if (req_rdata !== 32'hABCD1234) begin n_fail++; $display("FAIL rdata_after_writes: got %h expected abcd1234", req_rdata); end
    endtask

    task automatic test_stretch();
        int lat; logic [31:0] d;
        @(negedge clk);
        mem_lo = 16'h5A5A; mem_hi = 16'h0F0F;
        drive_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        lat = -1; d = 32'hx;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (req_ready) begin lat = n; d = req_rdata; break; end
            if (n == 3) sram_wait = 1'b1;
            if (n == 8) sram_wait = 1'b0;
        end
        drop_req(); sram_wait = 1'b0;
        n_tests++; if (lat !== 12) begin n_fail++; $display("FAIL stretch_latency: got %0d expected 12", lat); end
        n_tests++; if (d !== 32'h0F0F5A5A) begin n_fail++; $display("FAIL stretch_data: got %h expected 0f0f5a5a", d); end
    endtask

    task automatic test_back_to_back();
        int first, second; logic gap_busy;
        @(negedge clk);
        mem_lo = 16'h1111; mem_hi = 16'h2222;
        drive_req(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        first = -1; second = -1; gap_busy = 1'bx;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (first > 0 && n == first + 1) gap_busy = req_busy;
            if (req_ready) begin
                if (first < 0) first = n;
                else begin second = n; break; end
            end
        end
        drop_req();
        n_tests++; if (first !== 7 || second !== 15) begin n_fail++; $display("FAIL b2b_ready_cycles: got %0d,%0d expected 7,15", first, second); end
        n_tests++; if (gap_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", gap_busy); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic e; int rdy;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 32'h0000_0008, 32'h1357_9BDF, 4'hF);
        for (int n = 1; n <= 5; n++) @(negedge clk);
        n_tests++; if (sram_we !== 1'b1 || sram_addr[0] !== 1'b1) begin n_fail++; $display("FAIL mid_acc_hi_entry: got we=%b beat=%b expected 1 1", sram_we, sram_addr[0]); end
        rst = 1'b1;
        #1;
        n_tests++; if ({sram_ce, sram_we, sram_oe, req_ready, req_busy} !== 5'b0 || req_rdata !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got ce=%b we=%b oe=%b rdy=%b busy=%b rdata=%h expected all zero",
                               sram_ce, sram_we, sram_oe, req_ready, req_busy, req_rdata); end
        drop_req();
        rdy = 0;
        repeat (2) begin @(negedge clk); if (req_ready) rdy++; end
        rst = 1'b0;
        repeat (2) begin @(negedge clk); if (req_ready) rdy++; end
        n_tests++; if (rdy !== 0) begin n_fail++; $display("FAIL mid_reset_no_ready: got %0d pulses expected 0", rdy); end
        mem_lo = 16'h4444; mem_hi = 16'h3333;
        run_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'hF, lat, d, e);
        n_tests++; if (lat !== 7 || d !== 32'h33334444) begin n_fail++; $display("FAIL post_reset_read: got lat=%0d data=%h expected 7 33334444", lat, d); end
    endtask

`ifdef EXT_SRAM_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic [31:0] d; logic e;
        sram_wait = 1'b1;
        run_req(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, lat, d, e);
        sram_wait = 1'b0;
        n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 18", lat); end
        n_tests++; if (e !== 1'b1 || d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL timeout_abort: got err=%b data=%h expected 1 deadbeef", e, d); end
    endtask
`else
    task automatic test_wait_unbounded();
        int lat; int rdy; int errs; logic [31:0] d; logic e;
        @(negedge clk);
        mem_lo = 16'h7777; mem_hi = 16'h8888;
        sram_wait = 1'b1;
        drive_req(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        rdy = 0; errs = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (req_ready) rdy++;
            if (bus_err) errs++;
        end
        n_tests++; if (rdy !== 0 || errs !== 0 || req_busy !== 1'b1 || sram_oe !== 1'b1) begin
            n_fail++; $display("FAIL wait_held: got rdy=%0d err=%0d busy=%b oe=%b expected 0 0 1 1", rdy, errs, req_busy, sram_oe); end
        sram_wait = 1'b0;
        lat = -1; d = 32'hx; e = 1'bx;
        for (int n = 41; n <= 80; n++) begin
            @(negedge clk);
            if (req_ready) begin lat = n; d = req_rdata; e = bus_err; break; end
        end
        drop_req();
        n_tests++; if (lat !== 44 || d !== 32'h88887777 || e !== 1'b0) begin
            n_fail++; $display("FAIL wait_release: got lat=%0d data=%h err=%b expected 44 88887777 0", lat, d, e); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_enable = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        sram_wait = 1'b0; mem_lo = 16'h0; mem_hi = 16'h0;
        prev_we = 1'b0;
        clear_mon();

        test_reset();
        test_word_write();
        test_word_read();
        test_partial_write();
        test_stretch();
        test_back_to_back();
        test_reset_mid();
`ifdef EXT_SRAM_TIMEOUT_EN
        test_timeout();
`else
        test_wait_unbounded();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
